// File: rtl/m_wb_uart_if.sv
// ============================================================================
// Module  : m_wb_uart_if
// Brief   : Wishbone B4 classic bus bundle between the core (master) and the UART (slave).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface m_wb_uart_if;
  logic        CYC_I;
  logic        STB_I;
  logic        WE_I;
  logic        ADR_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        ACK_O;

  modport master (
    output CYC_I, STB_I, WE_I, ADR_I, DAT_I,
    input  DAT_O, ACK_O
  );

  modport slave (
    input  CYC_I, STB_I, WE_I, ADR_I, DAT_I,
    output DAT_O, ACK_O
  );
endinterface

`default_nettype wire

// File: rtl/m_wb_uart.sv
// ============================================================================
// Module  : m_wb_uart
// Brief   : Wishbone responder UART, 8N1, fixed baud divisor, small RX FIFO.
//           Optional macro UART_IRQ_EN adds the irq output and the rxie bit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module m_wb_uart #(
  parameter int BAUDDIV    = 104,
  parameter int RXFIFOLOG2 = 2
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  m_wb_uart_if.slave    wb,
  input  logic          usartRX,
  output logic          usartTX
`ifdef UART_IRQ_EN
  ,
  output logic          irq
`endif
);

  localparam int CW    = (BAUDDIV > 1) ? $clog2(BAUDDIV) : 1;
  localparam int DEPTH = 1 << RXFIFOLOG2;
  localparam int NW    = RXFIFOLOG2 + 1;
  localparam logic [CW-1:0] c_last  = CW'(BAUDDIV - 1);
  localparam logic [CW-1:0] c_half  = CW'(BAUDDIV / 2 - 1);
  localparam logic [NW-1:0] c_depth = NW'(DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  logic                  r_ack;
  logic [31:0]           r_dat;
  tx_state_t             r_tx_state, w_tx_nxt;
  logic [CW-1:0]         r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0]            r_tx_bit, w_tx_bit_nxt;
  logic [7:0]            r_tx_sh, w_tx_sh_nxt;
  logic                  r_txd, w_txd_nxt;
  logic                  r_rx_s1, r_rx_s2, r_rx_d;
  rx_state_t             r_rx_state, w_rx_nxt;
  logic [CW-1:0]         r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]            r_rx_bit, w_rx_bit_nxt;
  logic [7:0]            r_rx_sh, w_rx_sh_nxt;
  logic                  w_rx_done, w_ferr_set;
  logic [7:0]            r_mem [DEPTH];
  logic [RXFIFOLOG2-1:0] r_wptr, r_rptr;
  logic [NW-1:0]         r_cnt, w_cnt_nxt;
  logic                  r_ovr, r_ferr;
  logic                  w_rxie;
  logic [31:0]           w_rd_word;

  wire w_access   = wb.CYC_I & wb.STB_I & ~r_ack;
  wire w_wr_data  = w_access &  wb.WE_I & ~wb.ADR_I;
  wire w_rd_data  = w_access & ~wb.WE_I & ~wb.ADR_I;
  wire w_wr_stat  = w_access &  wb.WE_I &  wb.ADR_I;
  wire w_empty    = (r_cnt == '0);
  wire w_full     = (r_cnt == c_depth);
  wire w_pop      = w_rd_data & ~w_empty;
  wire w_push     = w_rx_done & (~w_full | w_pop);
  wire w_ovr_set  = w_rx_done & w_full & ~w_pop;
  wire w_txbusy   = (r_tx_state != TX_IDLE);
  wire w_unused   = ^wb.DAT_I;

  assign wb.ACK_O = r_ack;
  assign wb.DAT_O = r_dat;
  assign usartTX  = r_txd;

  always_comb begin
    w_tx_nxt     = r_tx_state;
    w_tx_cnt_nxt = r_tx_cnt + CW'(1);
    w_tx_bit_nxt = r_tx_bit;
    w_tx_sh_nxt  = r_tx_sh;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_cnt_nxt = '0;
        if (w_wr_data) begin
          w_tx_nxt    = TX_START;
          w_tx_sh_nxt = wb.DAT_I[7:0];
        end
      end
      TX_START: if (r_tx_cnt == c_last) begin
        w_tx_cnt_nxt = '0;
        w_tx_bit_nxt = '0;
        w_tx_nxt     = TX_DATA;
      end
      TX_DATA: if (r_tx_cnt == c_last) begin
        w_tx_cnt_nxt = '0;
        w_tx_sh_nxt  = {1'b0, r_tx_sh[7:1]};
        w_tx_bit_nxt = r_tx_bit + 3'd1;
        if (r_tx_bit == 3'd7) w_tx_nxt = TX_STOP;
      end
      TX_STOP: if (r_tx_cnt == c_last) begin
        w_tx_cnt_nxt = '0;
        w_tx_nxt     = TX_IDLE;
      end
      default: w_tx_nxt = TX_IDLE;
    endcase
    // Line level is registered from the next state so usartTX never glitches.
    case (w_tx_nxt)
      TX_START: w_txd_nxt = 1'b0;
      TX_DATA:  w_txd_nxt = w_tx_sh_nxt[0];
      default:  w_txd_nxt = 1'b1;
    endcase
  end

  always_comb begin
    w_rx_nxt     = r_rx_state;
    w_rx_cnt_nxt = r_rx_cnt + CW'(1);
    w_rx_bit_nxt = r_rx_bit;
    w_rx_sh_nxt  = r_rx_sh;
    w_rx_done    = 1'b0;
    w_ferr_set   = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_nxt = '0;
        if (r_rx_d & ~r_rx_s2) w_rx_nxt = RX_START;
      end
      RX_START: if (r_rx_cnt == c_half) begin
        w_rx_cnt_nxt = '0;
        w_rx_bit_nxt = '0;
        w_rx_nxt     = r_rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (r_rx_cnt == c_last) begin
        w_rx_cnt_nxt = '0;
        w_rx_sh_nxt  = {r_rx_s2, r_rx_sh[7:1]};
        w_rx_bit_nxt = r_rx_bit + 3'd1;
        if (r_rx_bit == 3'd7) w_rx_nxt = RX_STOP;
      end
      RX_STOP: if (r_rx_cnt == c_last) begin
        w_rx_cnt_nxt = '0;
        w_rx_done    = r_rx_s2;
        w_ferr_set   = ~r_rx_s2;
        w_rx_nxt     = r_rx_s2 ? RX_IDLE : RX_WAIT;
      end
      RX_WAIT: begin
        w_rx_cnt_nxt = '0;
        if (r_rx_s2) w_rx_nxt = RX_IDLE;
      end
      default: w_rx_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push & ~w_pop)      w_cnt_nxt = r_cnt + NW'(1);
    else if (w_pop & ~w_push) w_cnt_nxt = r_cnt - NW'(1);
    if (wb.ADR_I)
      w_rd_word = {27'b0, w_rxie, r_ferr, r_ovr, ~w_empty, w_txbusy};
    else if (w_empty)
      w_rd_word = 32'b0;
    else
      w_rd_word = {23'b0, 1'b1, r_mem[r_rptr]};
  end

  always_ff @(posedge CLK_I) begin
    if (w_push) r_mem[r_wptr] <= r_rx_sh;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_ack      <= 1'b0;
      r_dat      <= '0;
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_sh    <= '0;
      r_txd      <= 1'b1;
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_d     <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_sh    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_ovr      <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_ack      <= w_access;
      r_dat      <= (w_access & ~wb.WE_I) ? w_rd_word : 32'b0;
      r_tx_state <= w_tx_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_sh    <= w_tx_sh_nxt;
      r_txd      <= w_txd_nxt;
      r_rx_s1    <= usartRX;
      r_rx_s2    <= r_rx_s1;
      r_rx_d     <= r_rx_s2;
      r_rx_state <= w_rx_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_sh    <= w_rx_sh_nxt;
      r_cnt      <= w_cnt_nxt;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      // A new flag event outranks a same-edge write-1-to-clear.
      if (w_ovr_set)                       r_ovr  <= 1'b1;
      else if (w_wr_stat & wb.DAT_I[2])    r_ovr  <= 1'b0;
      if (w_ferr_set)                      r_ferr <= 1'b1;
      else if (w_wr_stat & wb.DAT_I[3])    r_ferr <= 1'b0;
    end
  end

`ifdef UART_IRQ_EN
  logic r_rxie, r_irq;
  wire  w_rxie_nxt = w_wr_stat ? wb.DAT_I[4] : r_rxie;
  assign w_rxie = r_rxie;
  assign irq    = r_irq;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_rxie <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      r_rxie <= w_rxie_nxt;
      r_irq  <= (w_cnt_nxt != '0) & w_rxie_nxt;
    end
  end
`else
  assign w_rxie = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_m_wb_uart.sv
// ============================================================================
// Module  : tb_m_wb_uart
// Brief   : Self-checking bench for m_wb_uart (BAUDDIV=8, RXFIFOLOG2=2).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_m_wb_uart;
  localparam int BAUD = 8;
  localparam int K_W = 0, K_R = 1, K_F = 2, K_G = 3;

  typedef struct {
    int          kind;
    logic        adr;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  logic CLK_I = 1'b0;
  logic RST_I = 1'b1;
  logic usartRX = 1'b1;
  logic usartTX;
`ifdef UART_IRQ_EN
  logic irq;
`endif

  m_wb_uart_if wb();

  m_wb_uart #(.BAUDDIV(BAUD), .RXFIFOLOG2(2)) dut (
    .CLK_I   (CLK_I),
    .RST_I   (RST_I),
    .wb      (wb),
    .usartRX (usartRX),
    .usartTX (usartTX)
`ifdef UART_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  always #5 CLK_I = ~CLK_I;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb_q[$];
  logic [7:0]  tx_exp[$];
  bit          mon_en = 1'b1;
  vec_t        vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic bus(input bit we, input bit adr, input logic [31:0] d);
    wb.CYC_I = 1'b1; wb.STB_I = 1'b1; wb.WE_I = we; wb.ADR_I = adr; wb.DAT_I = d;
    cyc();
    check("ack_rise", {31'b0, wb.ACK_O}, 32'd1);
    if (!we) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_underflow got 0x%0h expected none", wb.DAT_O);
      end else begin
        check(adr ? "rd_status" : "rd_data", wb.DAT_O, sb_q.pop_front());
      end
    end
    wb.CYC_I = 1'b0; wb.STB_I = 1'b0; wb.WE_I = 1'b0; wb.DAT_I = '0;
    cyc();
    check("ack_single", {31'b0, wb.ACK_O}, 32'd0);
    check("dat_idle", wb.DAT_O, 32'd0);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopb);
    logic [9:0] f;
    f = {stopb, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      usartRX = f[i];
      repeat (BAUD) cyc();
    end
    usartRX = 1'b1;
    repeat (2 * BAUD) cyc();
  endtask

  // Frame decoder on usartTX: samples mid-bit and checks against tx_exp.
  initial begin : tx_mon
    logic [7:0] mb;
    logic       mstop;
    forever begin
      @(negedge CLK_I);
      if (!RST_I && usartTX === 1'b0) begin
        repeat (BAUD + BAUD / 2) @(negedge CLK_I);
        mb[0] = usartTX;
        for (int j = 1; j < 8; j++) begin
          repeat (BAUD) @(negedge CLK_I);
          mb[j] = usartTX;
        end
        repeat (BAUD) @(negedge CLK_I);
        mstop = usartTX;
        if (mon_en) begin
          if (tx_exp.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_unexpected got 0x%0h expected none", mb);
          end else begin
            check("tx_byte", {24'b0, mb}, {24'b0, tx_exp.pop_front()});
            check("tx_stop", {31'b0, mstop}, 32'd1);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] a5;
    int         nbad;
    logic       e;

    vt.push_back('{K_F, 1'b0, 32'h13C, 32'h0});
    vt.push_back('{K_R, 1'b1, 32'h0,   32'h2});
    vt.push_back('{K_R, 1'b0, 32'h0,   32'h13C});
    vt.push_back('{K_R, 1'b0, 32'h0,   32'h0});
    vt.push_back('{K_R, 1'b1, 32'h0,   32'h0});
    for (int i = 1; i <= 5; i++) vt.push_back('{K_F, 1'b0, 32'h100 + i, 32'h0});
    vt.push_back('{K_R, 1'b1, 32'h0,   32'h6});
    for (int i = 1; i <= 4; i++) vt.push_back('{K_R, 1'b0, 32'h0, 32'h100 + i});
    vt.push_back('{K_R, 1'b0, 32'h0,   32'h0});
    vt.push_back('{K_R, 1'b1, 32'h0,   32'h4});
    vt.push_back('{K_W, 1'b1, 32'h4,   32'h0});
    vt.push_back('{K_R, 1'b1, 32'h0,   32'h0});
    vt.push_back('{K_F, 1'b0, 32'h077, 32'h0});
    vt.push_back('{K_R, 1'b1, 32'h0,   32'h8});
    vt.push_back('{K_R, 1'b0, 32'h0,   32'h0});
    vt.push_back('{K_G, 1'b0, 32'h0,   32'h0});
    vt.push_back('{K_R, 1'b1, 32'h0,   32'h8});
    vt.push_back('{K_R, 1'b0, 32'h0,   32'h0});
    vt.push_back('{K_W, 1'b1, 32'hF7,  32'h0});
    vt.push_back('{K_R, 1'b1, 32'h0,   32'h8});
    vt.push_back('{K_W, 1'b1, 32'h8,   32'h0});
    vt.push_back('{K_R, 1'b1, 32'h0,   32'h0});
    vt.push_back('{K_W, 1'b1, 32'h10,  32'h0});
`ifdef UART_IRQ_EN
    vt.push_back('{K_R, 1'b1, 32'h0,   32'h10});
`else
    vt.push_back('{K_R, 1'b1, 32'h0,   32'h0});
`endif
    vt.push_back('{K_W, 1'b1, 32'h0,   32'h0});
    vt.push_back('{K_R, 1'b1, 32'h0,   32'h0});

    wb.CYC_I = 1'b0; wb.STB_I = 1'b0; wb.WE_I = 1'b0; wb.ADR_I = 1'b0; wb.DAT_I = '0;
    repeat (3) cyc();
    check("rst_tx", {31'b0, usartTX}, 32'd1);
    check("rst_ack", {31'b0, wb.ACK_O}, 32'd0);
    check("rst_dat", wb.DAT_O, 32'd0);
`ifdef UART_IRQ_EN
    check("rst_irq", {31'b0, irq}, 32'd0);
`endif
    RST_I = 1'b0;
    cyc();
    sb_q.push_back(32'h0);
    bus(1'b0, 1'b1, 32'h0);

    // Cycle-exact TX waveform for 0xA5
    a5 = 8'hA5;
    tx_exp.push_back(a5);
    wb.CYC_I = 1'b1; wb.STB_I = 1'b1; wb.WE_I = 1'b1; wb.ADR_I = 1'b0; wb.DAT_I = 32'hFFFF_FFA5;
    cyc();
    check("wave_ack", {31'b0, wb.ACK_O}, 32'd1);
    wb.CYC_I = 1'b0; wb.STB_I = 1'b0; wb.WE_I = 1'b0;
    nbad = 0;
    for (int k = 0; k <= 10 * BAUD; k++) begin
      if (k < BAUD)           e = 1'b0;
      else if (k < 9 * BAUD)  e = a5[(k - BAUD) / BAUD];
      else                    e = 1'b1;
      if (usartTX !== e) nbad++;
      if (k == 1) check("wave_ack_low", {31'b0, wb.ACK_O}, 32'd0);
      cyc();
    end
    check("wave_bad_cycles", nbad, 0);

    // Busy window edges and drop of a write while busy
    tx_exp.push_back(8'h11);
    bus(1'b1, 1'b0, 32'h11);
    sb_q.push_back(32'h1);
    bus(1'b0, 1'b1, 32'h0);
    bus(1'b1, 1'b0, 32'h22);
    repeat (71) cyc();
    sb_q.push_back(32'h1);
    bus(1'b0, 1'b1, 32'h0);
    sb_q.push_back(32'h1);
    bus(1'b0, 1'b1, 32'h0);
    sb_q.push_back(32'h0);
    bus(1'b0, 1'b1, 32'h0);
    repeat (12 * BAUD) cyc();
    check("tx_drained", tx_exp.size(), 0);

    foreach (vt[i]) begin
      case (vt[i].kind)
        K_W: bus(1'b1, vt[i].adr, vt[i].d);
        K_R: begin
          sb_q.push_back(vt[i].exp);
          bus(1'b0, vt[i].adr, 32'h0);
        end
        K_F: send_frame(vt[i].d[7:0], vt[i].d[8]);
        default: begin
          usartRX = 1'b0;
          repeat (3) cyc();
          usartRX = 1'b1;
          repeat (3 * BAUD) cyc();
        end
      endcase
    end

`ifdef UART_IRQ_EN
    bus(1'b1, 1'b1, 32'h10);
    check("irq_idle", {31'b0, irq}, 32'd0);
    send_frame(8'h55, 1'b1);
    check("irq_set", {31'b0, irq}, 32'd1);
    sb_q.push_back(32'h155);
    bus(1'b0, 1'b0, 32'h0);
    check("irq_clear", {31'b0, irq}, 32'd0);
`endif

    // ACK never back-to-back while the strobe is held
    wb.CYC_I = 1'b1; wb.STB_I = 1'b1; wb.WE_I = 1'b0; wb.ADR_I = 1'b1;
    cyc();
    check("hold_ack1", {31'b0, wb.ACK_O}, 32'd1);
    cyc();
    check("hold_ack2", {31'b0, wb.ACK_O}, 32'd0);
    cyc();
    check("hold_ack3", {31'b0, wb.ACK_O}, 32'd1);
    wb.CYC_I = 1'b0; wb.STB_I = 1'b0;
    repeat (2) cyc();

    // Asynchronous reset in the middle of a frame
    mon_en = 1'b0;
    bus(1'b1, 1'b0, 32'h5A);
    repeat (BAUD) cyc();
    check("pre_rst_tx_low", {31'b0, usartTX}, 32'd0);
    #2;
    RST_I = 1'b1;
    #1;
    check("async_rst_tx", {31'b0, usartTX}, 32'd1);
    check("async_rst_ack", {31'b0, wb.ACK_O}, 32'd0);
`ifdef UART_IRQ_EN
    check("async_rst_irq", {31'b0, irq}, 32'd0);
`endif
    repeat (2) cyc();
    RST_I = 1'b0;
    cyc();
    sb_q.push_back(32'h0);
    bus(1'b0, 1'b1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
